// File: rtl/mul_seq_if.sv
// mul_seq_if: launch/abort controls and product result of the sequential multiplier.
interface mul_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, signed_op, a, b, flush,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, signed_op, a, b, flush,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mul_seq.sv
// mul_seq: iterative radix-2 shift-add multiplier (MULT/MULTU) for the EX stage.
// One partial-product add per cycle on operand magnitudes, then one cycle to
// apply the sign. The product lands in hi/lo together with a one-cycle done.
module mul_seq #(
   parameter int WIDTH = 32
) (
   input logic      clk,
   input logic      rst,
   mul_seq_if.slave mul
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_SIGN = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_nx_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   mcand_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [WIDTH-1:0]   acc_r;
   logic               neg_r;
   logic               busy_r;
   logic               done_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               busy_nx_s;
   logic               done_nx_s;
   logic               launch_s;
   logic [WIDTH:0]     sum_s;
   logic [2*WIDTH-1:0] prod_s;

   // Magnitude of an operand; raw value when the operation is unsigned.
   // The most negative value maps to 2^(WIDTH-1), which fits unsigned.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                               input logic is_signed);
      if (is_signed && v[WIDTH-1]) begin
         return ~v + WIDTH'(1);
      end else begin
         return v;
      end
   endfunction

   // Two's complement of a full-width product.
   function automatic logic [2*WIDTH-1:0] neg_prod(input logic [2*WIDTH-1:0] p);
      return ~p + (2*WIDTH)'(1);
   endfunction

   // A launch is accepted only outside RUN/SIGN, and flush blocks it.
   always_comb begin
      launch_s = 1'b0;
      if (((state_r == ST_IDLE) || (state_r == ST_DONE)) && mul.start && !mul.flush) begin
         launch_s = 1'b1;
      end else begin
         launch_s = 1'b0;
      end
   end

   // Partial-product add: carry-out kept as the extra top bit.
   always_comb begin
      sum_s = {1'b0, acc_r};
      if (mplier_r[0]) begin
         sum_s = {1'b0, acc_r} + {1'b0, mcand_r};
      end else begin
         sum_s = {1'b0, acc_r};
      end
   end

   // Signed result: magnitude product negated when operand signs differed.
   always_comb begin
      prod_s = {acc_r, mplier_r};
      if (neg_r) begin
         prod_s = neg_prod({acc_r, mplier_r});
      end else begin
         prod_s = {acc_r, mplier_r};
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; flush aborts RUN/SIGN straight back to IDLE.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (launch_s) state_nx_s = ST_RUN;
            else          state_nx_s = ST_IDLE;
         end
         ST_RUN: begin
            if (mul.flush)                 state_nx_s = ST_IDLE;
            else if (cnt_r == CNT_W'(1))   state_nx_s = ST_SIGN;
            else                           state_nx_s = ST_RUN;
         end
         ST_SIGN: begin
            if (mul.flush) state_nx_s = ST_IDLE;
            else           state_nx_s = ST_DONE;
         end
         ST_DONE: begin
            if (launch_s) state_nx_s = ST_RUN;
            else          state_nx_s = ST_IDLE;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Output decode from the next state so busy/done can be registered.
   always_comb begin
      busy_nx_s = 1'b0;
      done_nx_s = 1'b0;
      case (state_nx_s)
         ST_RUN:  busy_nx_s = 1'b1;
         ST_SIGN: busy_nx_s = 1'b1;
         ST_DONE: done_nx_s = 1'b1;
         default: begin
            busy_nx_s = 1'b0;
            done_nx_s = 1'b0;
         end
      endcase
   end

   // Registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= busy_nx_s;
         done_r <= done_nx_s;
      end
   end

   // Datapath: operand capture, shift-add iterations and result write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r    <= '0;
         mcand_r  <= '0;
         mplier_r <= '0;
         acc_r    <= '0;
         neg_r    <= 1'b0;
         hi_r     <= '0;
         lo_r     <= '0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (launch_s) begin
                  mcand_r  <= abs_val(mul.a, mul.signed_op);
                  mplier_r <= abs_val(mul.b, mul.signed_op);
                  neg_r    <= mul.signed_op & (mul.a[WIDTH-1] ^ mul.b[WIDTH-1]);
                  acc_r    <= '0;
                  cnt_r    <= CNT_W'(WIDTH);
               end
            end
            ST_RUN: begin
               // Shift {carry, acc, mplier} right: carry enters acc MSB and
               // the low acc bit moves into the vacated multiplier MSB.
               acc_r    <= sum_s[WIDTH:1];
               mplier_r <= {sum_s[0], mplier_r[WIDTH-1:1]};
               cnt_r    <= cnt_r - CNT_W'(1);
            end
            ST_SIGN: begin
               if (!mul.flush) begin
                  hi_r <= prod_s[2*WIDTH-1:WIDTH];
                  lo_r <= prod_s[WIDTH-1:0];
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign mul.busy = busy_r;
   assign mul.done = done_r;
   assign mul.hi   = hi_r;
   assign mul.lo   = lo_r;
endmodule
